tag_recycler: RTL and testbench

Multi-port in-order reclaim queue for released tags. Sits directly upstream of the free-list allocator: commit/retire logic pushes up to IN released tags per cycle (sparse valid vector), the block compacts and buffers them, and drains up to OUT tags per cycle onto the allocator's collect ports (`we`/`wd`). It decouples retire bandwidth from allocator write bandwidth and absorbs bursts.

---
 rtl/tag_recycler_pkg.sv | 23 ++
 rtl/vec_compact.sv | 30 +++
 rtl/tag_recycler.sv | 97 +++++++++
 tb/tb_tag_recycler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tag_recycler_pkg.sv
// Shared types and helpers for the tag_recycler reclaim queue.
// Default sizing lives here; the top may override it through its parameters.
package tag_recycler_pkg;
  localparam int P_DEPTH = 32;
  localparam int P_IN    = 4;
  localparam int P_OUT   = 4;
  localparam int P_TAG   = 6;
  localparam int P_CNT   = $clog2(P_DEPTH) + 1;

  typedef logic [P_TAG-1:0] tag_t;
  typedef logic [P_CNT-1:0] cnt_t;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += {31'd0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/vec_compact.sv
// Packs the valid lanes of a sparse vector into dense lanes starting at lane 0,
// preserving ascending lane order, and reports how many lanes were valid.
module vec_compact
  import tag_recycler_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 6,
  localparam int NW = $clog2(N + 1)
) (
  input  logic [N-1:0]        i_v,
  input  logic [N-1:0][W-1:0] i_tag,
  output logic [N-1:0][W-1:0] o_tag,
  output logic [NW-1:0]       o_n
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    logic [NW-1:0] idx;
    o_tag = '0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (i_v[i]) begin
        o_tag[idx[IW-1:0]] = i_tag[i];
        idx = idx + NW'(1);
      end
    end
  end

  assign o_n = NW'(popcount(32'(i_v)));
endmodule

// File: rtl/tag_recycler.sv
// In-order reclaim queue: compacts up to IN released tags per cycle and drains
// up to OUT per cycle. Optional same-cycle bypass: define TAG_RECYCLER_BYPASS_EN.
module tag_recycler
  import tag_recycler_pkg::*;
#(
  parameter int DEPTH = P_DEPTH,
  parameter int IN    = P_IN,
  parameter int OUT   = P_OUT,
  parameter int TAG   = P_TAG,
  localparam int CNT  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [IN-1:0]         in_v,
  input  logic [IN-1:0][TAG-1:0] in_tag,
  output logic                  in_ready,
  input  logic                  drain_en,
  output logic [OUT-1:0]        out_we,
  output logic [OUT-1:0][TAG-1:0] out_tag,
  output logic [CNT-1:0]        count
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(IN + 1);

  logic [TAG-1:0]          r_mem [DEPTH];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [CNT-1:0]          r_count;

  logic [IN-1:0][TAG-1:0]  w_cmp_tag;
  logic [NW-1:0]           w_cmp_n;
  logic                    w_push;
  logic [CNT-1:0]          w_n_in;
  logic [CNT-1:0]          w_n_out;

  vec_compact #(.N(IN), .W(TAG)) u_compact (
    .i_v   (in_v),
    .i_tag (in_tag),
    .o_tag (w_cmp_tag),
    .o_n   (w_cmp_n)
  );

  // Acceptance looks only at registered occupancy; a same-cycle drain earns no credit.
  assign in_ready = (r_count <= CNT'(DEPTH - IN));
  assign w_push   = in_ready && (|in_v);
  assign w_n_in   = w_push ? CNT'(w_cmp_n) : '0;
  assign count    = r_count;

  always_comb begin
    w_n_out = '0;
    out_we  = '0;
    out_tag = '0;
`ifdef TAG_RECYCLER_BYPASS_EN
    // Empty queue: the incoming group is written and read in the same cycle.
    if (r_count == '0) begin
      if (drain_en) w_n_out = CNT'(min_u(32'(w_n_in), OUT));
      for (int k = 0; k < OUT; k++) begin
        if (k < int'(w_n_out)) begin
          out_we[k]  = 1'b1;
          out_tag[k] = w_cmp_tag[k];
        end
      end
    end else
`endif
    begin
      if (drain_en) w_n_out = CNT'(min_u(32'(r_count), OUT));
      for (int k = 0; k < OUT; k++) begin
        if (k < int'(w_n_out)) begin
          out_we[k]  = 1'b1;
          out_tag[k] = r_mem[r_rptr + AW'(k)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && w_push) begin
      for (int k = 0; k < IN; k++) begin
        if (k < int'(w_cmp_n)) r_mem[r_wptr + AW'(k)] <= w_cmp_tag[k];
      end
    end
  end

  // Bypassed tags are still written, so both pointers advance uniformly.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_n_in);
      r_rptr  <= r_rptr + AW'(w_n_out);
      r_count <= r_count + w_n_in - w_n_out;
    end
  end
endmodule

// File: tb/tb_tag_recycler.sv
// Bench for tag_recycler: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_tag_recycler;
  localparam int DEPTH = 32;
  localparam int IN    = 4;
  localparam int OUT   = 4;
  localparam int TAG   = 6;
  localparam int CNT   = $clog2(DEPTH) + 1;

  logic                    clk;
  logic                    reset;
  logic                    flush;
  logic [IN-1:0]           in_v;
  logic [IN-1:0][TAG-1:0]  in_tag;
  logic                    in_ready;
  logic                    drain_en;
  logic [OUT-1:0]          out_we;
  logic [OUT-1:0][TAG-1:0] out_tag;
  logic [CNT-1:0]          count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  logic [TAG-1:0] exp_q[$];
  logic [TAG-1:0] new_q[$];
  logic [TAG-1:0] view_q[$];

  tag_recycler #(.DEPTH(DEPTH), .IN(IN), .OUT(OUT), .TAG(TAG)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_v     (in_v),
    .in_tag   (in_tag),
    .in_ready (in_ready),
    .drain_en (drain_en),
    .out_we   (out_we),
    .out_tag  (out_tag),
    .count    (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a plain queue of tags in arrival order.
  always @(negedge clk) begin
    if (chk_en) begin
      int  sz;
      int  nout;
      bit  push;
      bit  byp;
      logic [OUT-1:0] exp_we;
      logic [TAG-1:0] exp_tag;
      sz = exp_q.size();
      new_q.delete();
      for (int i = 0; i < IN; i++) if (in_v[i]) new_q.push_back(in_tag[i]);
      push = (sz <= DEPTH - IN) && (new_q.size() > 0);
      byp  = 1'b0;
`ifdef TAG_RECYCLER_BYPASS_EN
      byp = (sz == 0) && drain_en && push;
`endif
      view_q = byp ? new_q : exp_q;
      nout = drain_en ? ((view_q.size() < OUT) ? view_q.size() : OUT) : 0;
      exp_we = '0;
      for (int k = 0; k < OUT; k++) if (k < nout) exp_we[k] = 1'b1;
      chk("count", 32'(count), 32'(sz));
      chk("in_ready", 32'(in_ready), 32'(sz <= DEPTH - IN));
      chk("out_we", 32'(out_we), 32'(exp_we));
      for (int k = 0; k < OUT; k++) begin
        exp_tag = (k < nout) ? view_q[k] : '0;
        chk($sformatf("out_tag[%0d]", k), 32'(out_tag[k]), 32'(exp_tag));
      end
      if (reset || flush) begin
        exp_q.delete();
      end else begin
        if (push) foreach (new_q[i]) exp_q.push_back(new_q[i]);
        for (int k = 0; k < nout; k++) void'(exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [IN-1:0] v, input logic [TAG-1:0] t0, input logic [TAG-1:0] t1,
                       input logic [TAG-1:0] t2, input logic [TAG-1:0] t3, input logic d);
    in_v      = v;
    in_tag[0] = t0;
    in_tag[1] = t1;
    in_tag[2] = t2;
    in_tag[3] = t3;
    drain_en  = d;
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_v = '0; in_tag = '0; drain_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("reset count", 32'(count), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset out_we", 32'(out_we), 0);
    chk("reset out_tag", 32'(out_tag), 0);

    // Sparse group: lane1 = 5, lane3 = 9.
    drive(4'b1010, 6'd0, 6'd5, 6'd0, 6'd9, 1'b1);
`ifdef TAG_RECYCLER_BYPASS_EN
    chk("byp out_we", 32'(out_we), 32'h3);
    chk("byp lane0", 32'(out_tag[0]), 5);
    chk("byp lane1", 32'(out_tag[1]), 9);
    step();
    drive(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1);
    chk("byp count", 32'(count), 0);
    drive(4'b0111, 6'd11, 6'd12, 6'd13, 6'd0, 1'b1);
    chk("byp3 out_we", 32'(out_we), 32'h7);
    step();
    drive(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1);
    chk("byp3 count", 32'(count), 0);
`else
    step();
    drive(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1);
    chk("sparse count", 32'(count), 2);
    chk("sparse out_we", 32'(out_we), 32'h3);
    chk("sparse lane0", 32'(out_tag[0]), 5);
    chk("sparse lane1", 32'(out_tag[1]), 9);
    step();
    chk("sparse drained", 32'(count), 0);
`endif

    // Fill with drain disabled.
    for (int g = 0; g < 8; g++) begin
      drive(4'b1111, 6'(4*g), 6'(4*g+1), 6'(4*g+2), 6'(4*g+3), 1'b0);
      step();
      if (g == 6) begin
        chk("fill7 count", 32'(count), 28);
        chk("fill7 ready", 32'(in_ready), 1);
      end
    end
    chk("full count", 32'(count), 32);
    chk("full ready", 32'(in_ready), 0);
    drive(4'b1111, 6'd40, 6'd41, 6'd42, 6'd43, 1'b0);
    step();
    chk("reject count", 32'(count), 32);

    // Full with drain: group held, rejected this cycle, accepted the next.
    drive(4'b1111, 6'd40, 6'd41, 6'd42, 6'd43, 1'b1);
    chk("full drain out_we", 32'(out_we), 32'hf);
    chk("full drain lane0", 32'(out_tag[0]), 0);
    step();
    chk("after drain count", 32'(count), 28);
    drive(4'b1111, 6'd40, 6'd41, 6'd42, 6'd43, 1'b0);
    step();
    chk("refill count", 32'(count), 32);

    drive(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1);
    repeat (8) step();
    chk("empty count", 32'(count), 0);
    chk("empty out_we", 32'(out_we), 0);

    // Flush at occupancy 12 with a simultaneous push.
    for (int g = 0; g < 3; g++) begin
      drive(4'b1111, 6'(50+g), 6'(51+g), 6'(52+g), 6'(53+g), 1'b0);
      step();
    end
    chk("pre-flush count", 32'(count), 12);
    flush = 1'b1;
    drive(4'b1111, 6'd1, 6'd2, 6'd3, 6'd4, 1'b1);
    step();
    flush = 1'b0;
    drive(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b1);
    chk("flush count", 32'(count), 0);
    chk("flush out_we", 32'(out_we), 0);

    // Random traffic; pointers wrap many times, model checks order every cycle.
    for (int c = 0; c < 600; c++) begin
      flush = ($urandom_range(0, 59) == 0);
      drive(4'($urandom_range(0, 15)), 6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom),
            ($urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 4 : 8)));
      step();
    end
    flush = 1'b0;
    drive(4'b0000, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0);
    step();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
